// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing bitstream counter.
package sc_pkg;

    typedef enum logic [1:0] {SC_IDLE, SC_RUN, SC_DONE} sc_state_t;

    // Stream length exponents beyond the SNG width are saturated to a full-period run.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/sc_bit_counter.sv
// Ones/valid-bit counter pair; clear has priority over enable.
module sc_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic           z_i,
    output logic [WIDTH:0] ones_o,
    output logic [WIDTH:0] cycles_o
);

    logic [WIDTH:0] ones_q;
    logic [WIDTH:0] cycles_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ones_q   <= '0;
            cycles_q <= '0;
        end else if (clr_i) begin
            ones_q   <= '0;
            cycles_q <= '0;
        end else if (en_i) begin
            ones_q   <= ones_q + {{WIDTH{1'b0}}, z_i};
            cycles_q <= cycles_q + {{WIDTH{1'b0}}, 1'b1};
        end
    end

    assign ones_o   = ones_q;
    assign cycles_o = cycles_q;

endmodule

// File: rtl/sc_et_counter.sv
// Counts ones of a stochastic bitstream over 2^len_log2 valid bits, with optional
// threshold early termination and a one-cycle clear pulse to the upstream SNG.
module sc_et_counter
    import sc_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned LW    = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LW-1:0]  len_log2,
    input  logic [WIDTH:0] thresh,
    input  logic           et_en,
    input  logic           z,
    input  logic           z_valid,
    output logic           sng_clr,
    output logic           busy,
    output logic           done,
    output logic [WIDTH:0] ones,
    output logic [WIDTH:0] cycles,
    output logic [WIDTH:0] result,
    output logic           et_hit,
    output logic           decision
);

    sc_state_t      state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [WIDTH:0] thresh_q, thresh_d;
    logic           et_en_q, et_en_d;
    logic           et_hit_q, et_hit_d;
    logic           decision_q, decision_d;
    logic           sng_clr_q;

    logic [WIDTH:0]   ones_w, cycles_w;
    logic [WIDTH:0]   n_len, ones_n, cyc_n;
    logic [WIDTH+1:0] reach_sum;
    logic [LW-1:0]    shift_amt;
    logic             hit_above, hit_below, at_end;

    sc_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (start),
        .en_i     ((state_q == SC_RUN) && z_valid && !start),
        .z_i      (z),
        .ones_o   (ones_w),
        .cycles_o (cycles_w)
    );

    // Counts as they will stand after this edge's sample; ET compares against these.
    assign n_len     = {{WIDTH{1'b0}}, 1'b1} << len_q;
    assign ones_n    = ones_w + {{WIDTH{1'b0}}, z};
    assign cyc_n     = cycles_w + {{WIDTH{1'b0}}, 1'b1};
    assign reach_sum = {1'b0, ones_n} + {1'b0, n_len - cyc_n};
    assign hit_above = et_en_q && (ones_n >= thresh_q);
    assign hit_below = et_en_q && (reach_sum < {1'b0, thresh_q});
    assign at_end    = (cyc_n == n_len);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        thresh_d   = thresh_q;
        et_en_d    = et_en_q;
        et_hit_d   = et_hit_q;
        decision_d = decision_q;
        if (start) begin
            state_d    = SC_RUN;
            len_d      = LW'(clamp_len(32'(len_log2), WIDTH));
            thresh_d   = thresh;
            et_en_d    = et_en;
            et_hit_d   = 1'b0;
            decision_d = 1'b0;
        end else begin
            case (state_q)
                SC_RUN: begin
                    if (z_valid && (hit_above || hit_below || at_end)) begin
                        state_d    = SC_DONE;
                        decision_d = hit_above;
                        et_hit_d   = (hit_above || hit_below) && (cyc_n < n_len);
                    end
                end
                SC_DONE: state_d = SC_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SC_IDLE;
            len_q      <= '0;
            thresh_q   <= '0;
            et_en_q    <= 1'b0;
            et_hit_q   <= 1'b0;
            decision_q <= 1'b0;
            sng_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            thresh_q   <= thresh_d;
            et_en_q    <= et_en_d;
            et_hit_q   <= et_hit_d;
            decision_q <= decision_d;
            sng_clr_q  <= start;
        end
    end

    // Rescale the raw count to full scale 2^WIDTH.
    assign shift_amt = LW'(WIDTH) - len_q;
    assign result    = ones_w << shift_amt;

    assign sng_clr  = sng_clr_q;
    assign busy     = (state_q == SC_RUN);
    assign done     = (state_q == SC_DONE);
    assign ones     = ones_w;
    assign cycles   = cycles_w;
    assign et_hit   = et_hit_q;
    assign decision = decision_q;

endmodule

// File: tb/tb_sc_et_counter.sv
// Directed bench for sc_et_counter; z comes from a modelled SNG (mod-256 counter vs Bx).
module tb_sc_et_counter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LW    = 4;

    logic           clk = 1'b0;
    logic           rst, start, et_en, z, z_valid;
    logic [LW-1:0]  len_log2;
    logic [WIDTH:0] thresh;
    logic           sng_clr, busy, done, et_hit, decision;
    logic [WIDTH:0] ones, cycles, result;

    int vectors     = 0;
    int miscompares = 0;
    int r           = 0;
    int edges       = 0;

    sc_et_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len_log2 (len_log2),
        .thresh   (thresh),
        .et_en    (et_en),
        .z        (z),
        .z_valid  (z_valid),
        .sng_clr  (sng_clr),
        .busy     (busy),
        .done     (done),
        .ones     (ones),
        .cycles   (cycles),
        .result   (result),
        .et_hit   (et_hit),
        .decision (decision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input string tag, input logic [LW-1:0] l, input logic [WIDTH:0] th,
                             input logic e);
        start = 1'b1; len_log2 = l; thresh = th; et_en = e;
        tick();
        start = 1'b0;
        r = 0;
        check({tag, ".sng_clr"}, sng_clr, 1);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".clr_ones"}, ones, 0);
        check({tag, ".clr_cycles"}, cycles, 0);
    endtask

    // bx = number of SNG states (out of 256) that emit a 1; alt = z_valid every other cycle.
    task automatic drive(input string tag, input int bx, input bit alt, input int max_edges);
        edges = 0;
        for (int k = 0; k < max_edges; k++) begin
            z_valid = alt ? (k % 2 == 0) : 1'b1;
            z       = (r < bx);
            tick();
            edges++;
            if (z_valid) r = (r + 1) % 256;
            if (edges == 1) check({tag, ".sng_clr_drop"}, sng_clr, 0);
            if (done === 1'b1) break;
        end
        z_valid = 1'b0;
        z       = 1'b0;
    endtask

    task automatic expect_done(input string tag, input int exp_edges, input int exp_ones,
                               input int exp_cycles, input int exp_result, input int exp_et_hit,
                               input int exp_dec);
        check({tag, ".edges"}, edges, exp_edges);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".ones"}, ones, exp_ones);
        check({tag, ".cycles"}, cycles, exp_cycles);
        check({tag, ".result"}, result, exp_result);
        check({tag, ".et_hit"}, et_hit, exp_et_hit);
        check({tag, ".decision"}, decision, exp_dec);
        tick();
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".ones_hold"}, ones, exp_ones);
        check({tag, ".result_hold"}, result, exp_result);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; et_en = 1'b0; z = 1'b0; z_valid = 1'b0;
        len_log2 = '0; thresh = '0;
        tick(); tick();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.sng_clr", sng_clr, 0);
        check("rst.ones", ones, 0);
        check("rst.cycles", cycles, 0);
        check("rst.result", result, 0);
        check("rst.et_hit", et_hit, 0);
        check("rst.decision", decision, 0);
        rst = 1'b0;
        tick();

        // Full-length run, Bx=1100_0000 -> 192 of 256 states emit 1.
        begin_run("bx192", 4'd8, 9'd0, 1'b0);
        drive("bx192", 192, 1'b0, 600);
        expect_done("bx192", 256, 192, 256, 192, 0, 0);

        begin_run("bx3", 4'd8, 9'd0, 1'b0);
        drive("bx3", 3, 1'b0, 600);
        expect_done("bx3", 256, 3, 256, 3, 0, 0);

        begin_run("len4_ones", 4'd4, 9'd0, 1'b0);
        drive("len4_ones", 256, 1'b0, 600);
        expect_done("len4_ones", 16, 16, 16, 256, 0, 0);

        // ET above: two ones reach thresh=2 after 2 of 16 bits.
        begin_run("et_above", 4'd4, 9'd2, 1'b1);
        drive("et_above", 256, 1'b0, 600);
        expect_done("et_above", 2, 2, 2, 32, 1, 1);

        // ET below: 0 + (16-7) = 9 < 10 first holds at bit 7.
        begin_run("et_below", 4'd4, 9'd10, 1'b1);
        drive("et_below", 0, 1'b0, 600);
        expect_done("et_below", 7, 0, 7, 0, 1, 0);

        // thresh > N: first valid bit already makes reaching thresh impossible.
        begin_run("thr_gt_n", 4'd2, 9'd5, 1'b1);
        drive("thr_gt_n", 256, 1'b0, 600);
        expect_done("thr_gt_n", 1, 1, 1, 64, 1, 0);

        // len_log2 = 9 clamps to 8 (N = 256, no rescale shift).
        begin_run("clamp", 4'd9, 9'd1, 1'b1);
        drive("clamp", 256, 1'b0, 600);
        expect_done("clamp", 1, 1, 1, 1, 1, 1);

        begin_run("len0", 4'd0, 9'd0, 1'b0);
        drive("len0", 256, 1'b0, 600);
        expect_done("len0", 1, 1, 1, 256, 0, 0);

        // 50% z_valid: 16 valid bits land on edges 1,3,...,31.
        begin_run("gate", 4'd4, 9'd0, 1'b0);
        drive("gate", 256, 1'b1, 600);
        expect_done("gate", 31, 16, 16, 256, 0, 0);

        begin_run("restart_a", 4'd4, 9'd0, 1'b0);
        drive("restart_a", 256, 1'b0, 5);
        check("restart_a.cycles_mid", cycles, 5);
        begin_run("restart_b", 4'd4, 9'd0, 1'b0);
        drive("restart_b", 256, 1'b0, 600);
        expect_done("restart_b", 16, 16, 16, 256, 0, 0);

        // Asynchronous reset mid-run aborts with no done.
        begin_run("abort", 4'd4, 9'd0, 1'b0);
        drive("abort", 256, 1'b0, 5);
        rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.ones", ones, 0);
        check("abort.cycles", cycles, 0);
        check("abort.sng_clr", sng_clr, 0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            z_valid = 1'b1; z = 1'b1;
            tick();
            check("abort.no_done", done, 0);
        end
        z_valid = 1'b0; z = 1'b0;

        begin_run("post_abort", 4'd4, 9'd0, 1'b0);
        drive("post_abort", 256, 1'b0, 600);
        expect_done("post_abort", 16, 16, 16, 256, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
